// File: rtl/gray_wptr_gen_pkg.sv
// Shared constants and helpers for the gray write-pointer generator.
// Helpers work on a wide container; callers cast the result to their pointer width.
package gray_wptr_gen_pkg;

   localparam int BW_ADDR_DEF = 4;
   localparam int PW_MAX      = 32;

   typedef logic [PW_MAX-1:0] ptr_max_t;

   function automatic ptr_max_t bin2gray(input ptr_max_t x);
      return x ^ (x >> 1);
   endfunction

   // Write pointer equals this value when the FIFO is full: top two bits inverted.
   function automatic ptr_max_t full_cmp_val(input ptr_max_t rq, input int pw);
      return rq ^ (ptr_max_t'(3) << (pw - 2));
   endfunction

endpackage

// File: rtl/gray_sync2.sv
// Parameterised 2-flop synchroniser, async active-low reset to 0.
// Latency 2 i_clk edges; no flow control.
module gray_sync2 #(
   parameter int W = 5
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q1;
   logic [W-1:0] r_q2;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_q1 <= '0;
         r_q2 <= '0;
      end else begin
         r_q1 <= i_d;
         r_q2 <= r_q1;
      end
   end

   assign o_q = r_q2;

endmodule

// File: rtl/gray_wptr_gen.sv
// Write-side binary/gray pointer with registered full and overflow pulse; 1-cycle update.
// Writes while full are dropped; GRAY_WPTR_SYNC_EN adds a 2-flop sync on i_rptr_gray.
module gray_wptr_gen
   import gray_wptr_gen_pkg::*;
#(
   parameter int BW_ADDR = BW_ADDR_DEF
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_inc,
   input  logic [BW_ADDR:0]   i_rptr_gray,
   output logic [BW_ADDR-1:0] o_addr,
   output logic [BW_ADDR:0]   o_ptr_bin,
   output logic [BW_ADDR:0]   o_ptr_gray,
   output logic               o_full,
   output logic               o_ovf
);

   localparam int PW = BW_ADDR + 1;

   logic [PW-1:0] r_bin;
   logic [PW-1:0] r_gray;
   logic          r_full;
   logic          r_ovf;

   logic          w_we;
   logic [PW-1:0] w_bin_nxt;
   logic [PW-1:0] w_gray_nxt;
   logic [PW-1:0] w_rq;
   logic [PW-1:0] w_full_val;
   logic          w_full_nxt;

`ifdef GRAY_WPTR_SYNC_EN
   gray_sync2 #(.W(PW)) u_rptr_sync (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_d    (i_rptr_gray),
      .o_q    (w_rq)
   );
`else
   assign w_rq = i_rptr_gray;
`endif

   assign w_we       = i_inc & ~r_full;
   assign w_bin_nxt  = r_bin + PW'(w_we);
   assign w_gray_nxt = PW'(bin2gray(ptr_max_t'(w_bin_nxt)));
   assign w_full_val = PW'(full_cmp_val(ptr_max_t'(w_rq), PW));
   // Compare the next gray value so full asserts on the same edge as the filling write.
   assign w_full_nxt = (w_gray_nxt == w_full_val);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_full <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= w_gray_nxt;
         r_full <= w_full_nxt;
         r_ovf  <= i_inc & r_full;
      end
   end

   assign o_addr     = r_bin[BW_ADDR-1:0];
   assign o_ptr_bin  = r_bin;
   assign o_ptr_gray = r_gray;
   assign o_full     = r_full;
   assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_gray_wptr_gen.sv
// Directed plus random bench for gray_wptr_gen against a count-based reference model.
// Honours GRAY_WPTR_SYNC_EN by delaying the model's view of the read count by two edges.
module tb_gray_wptr_gen;

   localparam int BW  = 4;
   localparam int PW  = BW + 1;
   localparam int MOD = 1 << PW;

   logic          i_clk = 1'b0;
   logic          i_rstn;
   logic          i_inc;
   logic [PW-1:0] i_rptr_gray;
   logic [BW-1:0] o_addr;
   logic [PW-1:0] o_ptr_bin;
   logic [PW-1:0] o_ptr_gray;
   logic          o_full;
   logic          o_ovf;

   gray_wptr_gen #(.BW_ADDR(BW)) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_inc       (i_inc),
      .i_rptr_gray (i_rptr_gray),
      .o_addr      (o_addr),
      .o_ptr_bin   (o_ptr_bin),
      .o_ptr_gray  (o_ptr_gray),
      .o_full      (o_full),
      .o_ovf       (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: total writes/reads since reset, plus sync pipeline of read count.
   logic [PW-1:0] gtab [MOD];
   int  wr_tot, rd_tot, s1, s2;
   bit  m_full, m_ovf, m_we;
   logic [PW-1:0] prev_gray;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".bin"},  32'(o_ptr_bin),  32'(wr_tot % MOD));
      chk({tag, ".gray"}, 32'(o_ptr_gray), 32'(gtab[wr_tot % MOD]));
      chk({tag, ".addr"}, 32'(o_addr),     32'(wr_tot % (MOD / 2)));
      chk({tag, ".full"}, 32'(o_full),     32'(m_full));
      chk({tag, ".ovf"},  32'(o_ovf),      32'(m_ovf));
   endtask

   task automatic model_reset();
      wr_tot = 0; rd_tot = 0; s1 = 0; s2 = 0;
      m_full = 0; m_ovf = 0;
   endtask

   task automatic step(input bit inc, input string tag);
      int rq_eff;
      i_inc       = inc;
      i_rptr_gray = gtab[rd_tot % MOD];
`ifdef GRAY_WPTR_SYNC_EN
      rq_eff = s2;
`else
      rq_eff = rd_tot;
`endif
      m_we   = inc && !m_full;
      m_ovf  = inc && m_full;
      wr_tot = wr_tot + (m_we ? 1 : 0);
      m_full = ((wr_tot - rq_eff) == MOD / 2);
      s2 = s1;
      s1 = rd_tot;
      prev_gray = o_ptr_gray;
      @(posedge i_clk);
      #1;
      chk_all(tag);
      chk({tag, ".onebit"}, 32'($countones(o_ptr_gray ^ prev_gray)), m_we ? 32'd1 : 32'd0);
   endtask

   initial begin
      // Reflect-and-prefix construction of the gray sequence.
      gtab[0] = '0;
      for (int k = 0; k < PW; k++)
         for (int i = 0; i < (1 << k); i++)
            gtab[(1 << k) + i] = PW'(1 << k) | gtab[(1 << k) - 1 - i];

      model_reset();
      i_rstn = 1'b0; i_inc = 1'b0; i_rptr_gray = '0;
      #2;
      chk_all("reset");
      #1 i_rstn = 1'b1;

      for (int i = 0; i < 7; i++) step(1'b1, "pre_rst");
      chk("pre_rst.bin7", 32'(o_ptr_bin), 32'd7);
      #3 i_rstn = 1'b0;
      #1;
      model_reset();
      chk_all("async_rst");
      #2 i_rstn = 1'b1;

      for (int i = 0; i < 15; i++) step(1'b1, "gray_seq");
      chk("gray_seq.g15", 32'(o_ptr_gray), 32'b01000);
      step(1'b1, "fill");
      chk("fill.gray", 32'(o_ptr_gray), 32'b11000);
      chk("fill.full", 32'(o_full), 32'd1);

      for (int i = 0; i < 3; i++) step(1'b1, "ovf");
      chk("ovf.bin", 32'(o_ptr_bin), 32'd16);

      rd_tot = 16;
      for (int i = 0; i < 3; i++) step(1'b0, "drain");
      chk("drain.full", 32'(o_full), 32'd0);
      for (int i = 0; i < 16; i++) step(1'b1, "wrap");
      chk("wrap.bin", 32'(o_ptr_bin), 32'd0);
      chk("wrap.full", 32'(o_full), 32'd1);

      rd_tot = 17;
      step(1'b1, "simul");
      for (int i = 0; i < 4; i++) step(1'b1, "after_simul");

      for (int i = 0; i < 400; i++) begin
         if (rd_tot < wr_tot && $urandom_range(0, 2) == 0) rd_tot++;
         step(1'($urandom_range(0, 1)), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
